// File: rtl/axi4_write_master.sv
// AXI4 write master: accepts one burst command, issues AW, streams W beats from
// s_* with combinational pass-through, waits for B, then pulses done.
module axi4_write_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  err_local
);

    // Every channel uses valid/ready: a transfer happens on a rising edge where
    // both are high; valid, once raised, holds its payload stable until then.
    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, REJECT} state_t;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt;
    logic                  cmd_hs, aw_hs, w_hs, b_hs;
    logic                  bad_align, cross_4k;
    logic [10:0]           end_word;

    assign cmd_hs    = cmd_valid && cmd_ready;
    assign aw_hs     = AWVALID && AWREADY;
    assign w_hs      = WVALID && WREADY;
    assign b_hs      = BVALID && BREADY;
    // Last word index of the burst within its 4 KB page; above 1023 it spills over.
    assign end_word  = {1'b0, cmd_addr[11:2]} + {3'b000, cmd_len};
    assign bad_align = (cmd_addr[1:0] != 2'b00);
    assign cross_4k  = (end_word > 11'd1023);

    assign AWADDR = addr_q;
    assign AWLEN  = len_q;
    assign AWSIZE = 3'b010;
    assign WDATA  = s_data;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_hs) next_state = (bad_align || cross_4k) ? REJECT : ADDR;
            ADDR:    if (aw_hs) next_state = DATA;
            DATA:    if (w_hs && WLAST) next_state = RESP;
            RESP:    if (b_hs) next_state = IDLE;
            REJECT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // done is registered, so the cycle it is high the FSM is already idle;
    // holding cmd_ready low there keeps the next accept strictly after done.
    always_comb begin
        cmd_ready = (state == IDLE) && !done && !ARESET;
        AWVALID   = (state == ADDR);
        WVALID    = (state == DATA) && s_valid;
        s_ready   = (state == DATA) && WREADY;
        WLAST     = (state == DATA) && (beat_cnt == len_q);
        BREADY    = (state == RESP);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            addr_q    <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            done      <= 1'b0;
            done_resp <= 2'b00;
            err_local <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cmd_hs) begin
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
            end
            if (aw_hs)     beat_cnt <= '0;
            else if (w_hs) beat_cnt <= beat_cnt + 8'd1;
            if (cmd_hs && (bad_align || cross_4k)) begin
                done      <= 1'b1;
                done_resp <= 2'b10;
                err_local <= 1'b1;
            end else if (b_hs) begin
                done      <= 1'b1;
                done_resp <= BRESP;
                err_local <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_write_master.sv
// Directed bench for axi4_write_master: reset, single beat, backpressure,
// local rejects, mid-burst reset and slave error propagation.
module tb_axi4_write_master;

    logic        ACLK, ARESET;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        s_valid, s_ready;
    logic [31:0] s_data;
    logic [15:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic        AWVALID, AWREADY;
    logic [31:0] WDATA;
    logic        WLAST, WVALID, WREADY;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY;
    logic        done;
    logic [1:0]  done_resp;
    logic        err_local;

    int errors = 0;
    int checks = 0;

    axi4_write_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .done(done), .done_resp(done_resp), .err_local(err_local)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic idle_inputs();
        cmd_valid = 0; cmd_addr = 0; cmd_len = 0;
        s_valid = 0; s_data = 0;
        AWREADY = 0; WREADY = 0; BRESP = 0; BVALID = 0;
    endtask

    // Offers one command against an always-ready slave and tallies the traffic.
    task automatic drive_burst(input logic [15:0] addr, input logic [7:0] len,
                               input logic [1:0] resp,
                               output int aw_n, output int w_n, output int wlast_n,
                               output int done_n, output logic [1:0] d_resp,
                               output logic d_err);
        aw_n = 0; w_n = 0; wlast_n = 0; done_n = 0; d_resp = 2'bxx; d_err = 1'bx;
        @(posedge ACLK); #1;
        cmd_valid = 1; cmd_addr = addr; cmd_len = len;
        AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = resp; s_valid = 1;
        s_data = 32'hC000_0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge ACLK);
            if (cmd_ready) break;
            @(posedge ACLK); #1;
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge ACLK); #1;
            cmd_valid = 0;
            s_data = 32'hC000_0000 + w_n;
            @(negedge ACLK);
            if (AWVALID && AWREADY) aw_n++;
            if (WVALID && WREADY) begin
                w_n++;
                if (WLAST) wlast_n++;
            end
            if (done) begin
                done_n++;
                d_resp = done_resp;
                d_err  = err_local;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
        checks++; if ({AWVALID, WVALID, WLAST, BREADY, s_ready, done, err_local} !== 7'b0)
            begin errors++; $display("FAIL reset_ctrl: got %b want 0000000", {AWVALID, WVALID, WLAST, BREADY, s_ready, done, err_local}); end
        checks++; if ({done_resp, AWADDR, AWLEN, AWSIZE} !== {2'b00, 16'h0, 8'h0, 3'b010})
            begin errors++; $display("FAIL reset_regs: got %h/%h/%h/%h want 0/0/0/2", done_resp, AWADDR, AWLEN, AWSIZE); end
        repeat (2) @(posedge ACLK);
        #1 ARESET = 0;
        @(negedge ACLK);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_single_beat();
        @(posedge ACLK); #1;
        cmd_valid = 1; cmd_addr = 16'h0010; cmd_len = 0;
        AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'b00; s_valid = 1; s_data = 32'hDEADBEEF;
        @(negedge ACLK);
        checks++; if (cmd_ready !== 1'b1 || AWVALID !== 1'b0) begin errors++; $display("FAIL sb_c0: got ready=%b awvalid=%b want 1 0", cmd_ready, AWVALID); end
        @(posedge ACLK); #1 cmd_valid = 0;
        @(negedge ACLK);
        checks++; if ({AWVALID, AWADDR, AWLEN, AWSIZE} !== {1'b1, 16'h0010, 8'h00, 3'b010})
            begin errors++; $display("FAIL sb_c1_aw: got v=%b a=%h l=%h s=%h want 1 0010 00 2", AWVALID, AWADDR, AWLEN, AWSIZE); end
        checks++; if (BREADY !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL sb_c1_idle: got bready=%b cmd_ready=%b want 0 0", BREADY, cmd_ready); end
        @(negedge ACLK);
        checks++; if ({WVALID, WLAST, s_ready, WDATA} !== {3'b111, 32'hDEADBEEF})
            begin errors++; $display("FAIL sb_c2_w: got v=%b l=%b r=%b d=%h want 1 1 1 deadbeef", WVALID, WLAST, s_ready, WDATA); end
        @(negedge ACLK);
        checks++; if ({BREADY, WVALID, s_ready, done} !== 4'b1000) begin errors++; $display("FAIL sb_c3_b: got %b want 1000", {BREADY, WVALID, s_ready, done}); end
        @(negedge ACLK);
        checks++; if ({done, done_resp, err_local, cmd_ready} !== 5'b1_00_0_0)
            begin errors++; $display("FAIL sb_c4_done: got %b want 10000", {done, done_resp, err_local, cmd_ready}); end
        @(negedge ACLK);
        checks++; if ({done, cmd_ready} !== 2'b01) begin errors++; $display("FAIL sb_c5: got done=%b cmd_ready=%b want 0 1", done, cmd_ready); end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int aw_high = 0, aw_n = 0, w_n = 0, done_n = 0;
        @(posedge ACLK); #1;
        cmd_valid = 1; cmd_addr = 16'h0100; cmd_len = 8'd3;
        AWREADY = 0; WREADY = 1; s_valid = 1; s_data = 32'hA000_0000; BVALID = 0;
        @(negedge ACLK);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b want 1", cmd_ready); end
        for (int c = 0; c < 40; c++) begin
            @(posedge ACLK); #1;
            cmd_valid = 0;
            AWREADY = (aw_high >= 3);
            WREADY = ~WREADY;
            s_data = 32'hA000_0000 + w_n;
            BVALID = 1;
            @(negedge ACLK);
            if (AWVALID) begin
                aw_high++;
                checks++; if (AWADDR !== 16'h0100 || AWLEN !== 8'd3)
                    begin errors++; $display("FAIL bp_aw_stable: got %h/%h want 0100/03", AWADDR, AWLEN); end
                if (AWREADY) aw_n++;
            end
            if (WVALID && WREADY) begin
                w_n++;
                checks++; if (WLAST !== (w_n == 4)) begin errors++; $display("FAIL bp_wlast: beat %0d got %b want %b", w_n, WLAST, (w_n == 4)); end
                checks++; if (WDATA !== 32'hA000_0000 + w_n - 1) begin errors++; $display("FAIL bp_wdata: got %h want %h", WDATA, 32'hA000_0000 + w_n - 1); end
            end
            if (done) done_n++;
        end
        checks++; if (aw_high !== 4 || aw_n !== 1) begin errors++; $display("FAIL bp_aw_cycles: got high=%0d hs=%0d want 4 1", aw_high, aw_n); end
        checks++; if (w_n !== 4) begin errors++; $display("FAIL bp_w_count: got %0d want 4", w_n); end
        checks++; if (done_n !== 1 || done_resp !== 2'b00) begin errors++; $display("FAIL bp_done: got n=%0d resp=%b want 1 00", done_n, done_resp); end
        idle_inputs();
    endtask

    task automatic test_misaligned();
        @(posedge ACLK); #1;
        cmd_valid = 1; cmd_addr = 16'h0002; cmd_len = 0; AWREADY = 1; WREADY = 1; s_valid = 1;
        @(negedge ACLK);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mis_accept: got %b want 1", cmd_ready); end
        @(posedge ACLK); #1 cmd_valid = 0;
        @(negedge ACLK);
        checks++; if ({done, done_resp, err_local, AWVALID, WVALID} !== 6'b1_10_1_0_0)
            begin errors++; $display("FAIL mis_done: got %b want 110100", {done, done_resp, err_local, AWVALID, WVALID}); end
        @(negedge ACLK);
        checks++; if ({done, cmd_ready, AWVALID, done_resp, err_local} !== 6'b0_1_0_10_1)
            begin errors++; $display("FAIL mis_after: got %b want 010101", {done, cmd_ready, AWVALID, done_resp, err_local}); end
        idle_inputs();
    endtask

    task automatic test_4k_boundary();
        int aw_n, w_n, wl_n, d_n;
        logic [1:0] r;
        logic e;
        drive_burst(16'h0FF8, 8'd2, 2'b00, aw_n, w_n, wl_n, d_n, r, e);
        checks++; if (aw_n !== 0 || w_n !== 0) begin errors++; $display("FAIL 4k_reject_traffic: got aw=%0d w=%0d want 0 0", aw_n, w_n); end
        checks++; if (d_n !== 1 || r !== 2'b10 || e !== 1'b1) begin errors++; $display("FAIL 4k_reject_done: got n=%0d resp=%b err=%b want 1 10 1", d_n, r, e); end
        drive_burst(16'h0FF8, 8'd1, 2'b00, aw_n, w_n, wl_n, d_n, r, e);
        checks++; if (aw_n !== 1 || w_n !== 2 || wl_n !== 1) begin errors++; $display("FAIL 4k_accept_traffic: got aw=%0d w=%0d last=%0d want 1 2 1", aw_n, w_n, wl_n); end
        checks++; if (d_n !== 1 || r !== 2'b00 || e !== 1'b0) begin errors++; $display("FAIL 4k_accept_done: got n=%0d resp=%b err=%b want 1 00 0", d_n, r, e); end
    endtask

    task automatic test_reset_mid_burst();
        int w_n = 0, d_n = 0, aw_n, wl_n;
        logic [1:0] r;
        logic e;
        @(posedge ACLK); #1;
        cmd_valid = 1; cmd_addr = 16'h0200; cmd_len = 8'd3;
        AWREADY = 1; WREADY = 1; BVALID = 1; s_valid = 1; s_data = 32'h5555_0000;
        for (int c = 0; c < 20 && w_n < 2; c++) begin
            @(negedge ACLK);
            if (WVALID && WREADY) w_n++;
            @(posedge ACLK); #1 cmd_valid = 0;
        end
        checks++; if (w_n !== 2 || WVALID !== 1'b1) begin errors++; $display("FAIL rst_pre: got beats=%0d wvalid=%b want 2 1", w_n, WVALID); end
        #2 ARESET = 1;
        #1;
        checks++; if ({WVALID, s_ready, BREADY, WLAST, AWVALID, cmd_ready, done} !== 7'b0)
            begin errors++; $display("FAIL rst_async: got %b want 0000000", {WVALID, s_ready, BREADY, WLAST, AWVALID, cmd_ready, done}); end
        repeat (2) @(posedge ACLK);
        #1 ARESET = 0;
        @(negedge ACLK);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
        idle_inputs();
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            if (done) d_n++;
        end
        checks++; if (d_n !== 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses want 0", d_n); end
        drive_burst(16'h0300, 8'd1, 2'b00, aw_n, w_n, wl_n, d_n, r, e);
        checks++; if (w_n !== 2 || d_n !== 1 || r !== 2'b00) begin errors++; $display("FAIL rst_next_burst: got w=%0d done=%0d resp=%b want 2 1 00", w_n, d_n, r); end
    endtask

    task automatic test_error_resp();
        int aw_n, w_n, wl_n, d_n;
        logic [1:0] r;
        logic e;
        drive_burst(16'h0040, 8'd0, 2'b10, aw_n, w_n, wl_n, d_n, r, e);
        checks++; if (w_n !== 1 || d_n !== 1) begin errors++; $display("FAIL slverr_traffic: got w=%0d done=%0d want 1 1", w_n, d_n); end
        checks++; if (r !== 2'b10 || e !== 1'b0) begin errors++; $display("FAIL slverr_resp: got resp=%b err=%b want 10 0", r, e); end
        checks++; if (done_resp !== 2'b10 || err_local !== 1'b0) begin errors++; $display("FAIL slverr_hold: got resp=%b err=%b want 10 0", done_resp, err_local); end
    endtask

    initial begin
        ARESET = 1;
        idle_inputs();
        test_reset();
        test_single_beat();
        test_backpressure();
        test_misaligned();
        test_4k_boundary();
        test_reset_mid_burst();
        test_error_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
